// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: buffer state encoding, default widths and the
// bit layout of the decoded control bundle.
package pipe_stage_reg_pkg;

  localparam int unsigned DEFAULT_DATA_W = 134;
  localparam int unsigned DEFAULT_CTRL_W = 17;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } bufState_t;

  // Control bundle: {jType, memWrite, memRead, pcImmSel[3:0], aluSel[3:0], regWrite, wAddr[4:0]}
  localparam int unsigned CTRL_WADDR_LSB  = 0;
  localparam int unsigned CTRL_WADDR_W    = 5;
  localparam int unsigned CTRL_REGWRITE   = 5;
  localparam int unsigned CTRL_ALUSEL_LSB = 6;
  localparam int unsigned CTRL_ALUSEL_W   = 4;
  localparam int unsigned CTRL_PCIMM_LSB  = 10;
  localparam int unsigned CTRL_PCIMM_W    = 4;
  localparam int unsigned CTRL_MEMREAD    = 14;
  localparam int unsigned CTRL_MEMWRITE   = 15;
  localparam int unsigned CTRL_JTYPE      = 16;

  function automatic logic [1:0] stateOcc(input bufState_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {valid, ctrl, data}; clear wins over load and leaves a
// bubble with all-zero control.
module pipe_entry_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic [DATA_W-1:0] inData,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= inCtrl;
      data  <= inData;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: plain register (SKID=0) or two-entry skid buffer
// (SKID=1) with flush and bubble insertion.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  generate
    if (SKID == 0) begin : gSingle
      logic mainValid;
      logic accept;
      logic deq;

      assign in_ready = !mainValid | out_ready;
      assign accept   = in_valid & in_ready;
      assign deq      = mainValid & out_ready;

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) mainEntry (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .clear  (flush | (deq & !accept)),
        .inCtrl (in_ctrl),
        .inData (in_data),
        .valid  (mainValid),
        .ctrl   (out_ctrl),
        .data   (out_data)
      );

      assign out_valid = mainValid;
      assign occupancy = {1'b0, mainValid};
    end else begin : gSkid
      bufState_t         state;
      bufState_t         stateNext;
      logic              mainValid;
      logic              skidValid;
      logic [CTRL_W-1:0] skidCtrl;
      logic [DATA_W-1:0] skidData;
      logic              accept;
      logic              deq;
      logic              mainLoad;
      logic              mainClear;
      logic              mainFromSkid;
      logic              skidLoad;
      logic              skidClear;

      // skidValid is itself a flop, so in_ready has no path from out_ready.
      assign in_ready = !skidValid;
      assign accept   = in_valid & in_ready;
      assign deq      = mainValid & out_ready;

      always_comb begin
        stateNext    = state;
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        if (flush) begin
          stateNext = EMPTY;
          mainClear = 1'b1;
          skidClear = 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                mainLoad  = 1'b1;
                stateNext = ONE;
              end
            end
            ONE: begin
              if (accept && !deq) begin
                skidLoad  = 1'b1;
                stateNext = TWO;
              end else if (accept && deq) begin
                mainLoad = 1'b1;
              end else if (deq) begin
                mainClear = 1'b1;
                stateNext = EMPTY;
              end
            end
            TWO: begin
              if (deq) begin
                mainLoad     = 1'b1;
                mainFromSkid = 1'b1;
                skidClear    = 1'b1;
                stateNext    = ONE;
              end
            end
            default: begin
              stateNext = EMPTY;
              mainClear = 1'b1;
              skidClear = 1'b1;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= stateNext;
      end

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) mainEntry (
        .clk    (clk),
        .reset  (reset),
        .load   (mainLoad),
        .clear  (mainClear),
        .inCtrl (mainFromSkid ? skidCtrl : in_ctrl),
        .inData (mainFromSkid ? skidData : in_data),
        .valid  (mainValid),
        .ctrl   (out_ctrl),
        .data   (out_data)
      );

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) skidEntry (
        .clk    (clk),
        .reset  (reset),
        .load   (skidLoad),
        .clear  (skidClear),
        .inCtrl (in_ctrl),
        .inData (in_data),
        .valid  (skidValid),
        .ctrl   (skidCtrl),
        .data   (skidData)
      );

      assign out_valid = mainValid;
      assign occupancy = stateOcc(state);
    end
  endgenerate

endmodule
